// File: rtl/jtag_ahb_pkg.sv
// -----------------------------------------------------------------------------
// jtag_ahb_pkg
// Shared constants and types for the JTAG-to-AHB-Lite transfer sequencer:
//   HTRANS_IDLE / HTRANS_NONSEQ  AHB-Lite transfer type encodings
//   HSIZE_WORD                   32-bit transfer size encoding
//   state_e                      sequencer FSM states
// -----------------------------------------------------------------------------
package jtag_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_e;

endpackage

// File: rtl/jtag_ahb_watchdog.sv
// -----------------------------------------------------------------------------
// jtag_ahb_watchdog
// Data-phase wait-state counter for the sequencer. Only instantiated when
// JTAG_AHB_TIMEOUT_EN is defined.
// Ports:
//   clk_i      clock, rising edge
//   rst_n_i    asynchronous active-low reset
//   clr_i      clear the count (data-phase entry)
//   en_i       count one wait cycle
//   expired_o  this wait cycle is the TIMEOUT_CYCLES-th one; the sequencer
//              leaves the data phase on the same edge
// -----------------------------------------------------------------------------
module jtag_ahb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires on the wait cycle that brings the count to TIMEOUT_CYCLES.
    assign expired_o = en_i && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/jtag_ahb_sequencer.sv
// -----------------------------------------------------------------------------
// jtag_ahb_sequencer
// Turns one TAP command (read/write, start address, beat count) into a series
// of non-pipelined single-word AHB-Lite NONSEQ transfers with an
// auto-incrementing address, returning one response per beat.
// Optional: define JTAG_AHB_TIMEOUT_EN to bound data-phase wait states to
// TIMEOUT_CYCLES; otherwise the data phase waits indefinitely and rsp_timeout
// is always 0.
// Ports:
//   TCK, TRST_N              clock / asynchronous active-low reset
//   cmd_valid/cmd_ready      command handshake (ready only when idle)
//   cmd_write, cmd_addr,
//   cmd_wdata, cmd_len       command fields (len = beats - 1, fill write data)
//   rsp_valid/rsp_ready      per-beat response handshake
//   rsp_rdata, rsp_err,
//   rsp_timeout, rsp_last    response fields, stable while rsp_valid
//   busy                     FSM not idle
//   HADDR..HWDATA            AHB-Lite master outputs
//   HREADY, HRESP, HRDATA    AHB-Lite master inputs
// -----------------------------------------------------------------------------
module jtag_ahb_sequencer
    import jtag_ahb_pkg::*;
#(
    parameter int unsigned LEN_W          = 8,
    parameter int unsigned ADDR_INC       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             TCK,
    input  logic             TRST_N,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [31:0]      cmd_addr,
    input  logic [31:0]      cmd_wdata,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    output logic             rsp_timeout,
    output logic             rsp_last,
    output logic             busy,
    output logic [31:0]      HADDR,
    output logic [1:0]       HTRANS,
    output logic             HWRITE,
    output logic [2:0]       HSIZE,
    output logic [31:0]      HWDATA,
    input  logic             HREADY,
    input  logic             HRESP,
    input  logic [31:0]      HRDATA
);

    state_e           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             write_q, write_d;
    logic [LEN_W-1:0] remain_q, remain_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             tmo_q, tmo_d;
    logic             beat_last;
    logic             wd_expired;

`ifdef JTAG_AHB_TIMEOUT_EN
    jtag_ahb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i     (TCK),
        .rst_n_i   (TRST_N),
        .clr_i     ((state_q == ADDR) && HREADY),
        .en_i      ((state_q == DATA) && !HREADY),
        .expired_o (wd_expired)
    );
`else
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
    assign wd_expired = 1'b0;
`endif

    // An error or timeout aborts whatever beats remain.
    assign beat_last = (remain_q == '0) || err_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        write_d  = write_q;
        remain_d = remain_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        tmo_d    = tmo_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d   = cmd_addr;
                    wdata_d  = cmd_wdata;
                    write_d  = cmd_write;
                    remain_d = cmd_len;
                    state_d  = ADDR;
                end
            end
            ADDR: begin
                if (HREADY) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (HREADY) begin
                    state_d = RESP;
                    err_d   = HRESP;
                    tmo_d   = 1'b0;
                    rdata_d = (write_q || HRESP) ? '0 : HRDATA;
                end else if (wd_expired) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    if (beat_last) begin
                        state_d = IDLE;
                    end else begin
                        addr_d   = addr_q + 32'(ADDR_INC);
                        remain_d = remain_q - LEN_W'(1);
                        state_d  = ADDR;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            remain_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            write_q  <= write_d;
            remain_q <= remain_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign rsp_valid   = (state_q == RESP);
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = rsp_valid && err_q;
    assign rsp_timeout = rsp_valid && tmo_q;
    assign rsp_last    = rsp_valid && beat_last;

    // Address and direction are registered, so they hold after the address
    // phase until the next beat's address phase.
    assign HTRANS = (state_q == ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR  = addr_q;
    assign HWRITE = write_q;
    assign HSIZE  = HSIZE_WORD;
    assign HWDATA = wdata_q;

endmodule

// File: tb/tb_jtag_ahb_sequencer.sv
// -----------------------------------------------------------------------------
// tb_jtag_ahb_sequencer
// Directed bench for jtag_ahb_sequencer. Define JTAG_AHB_TIMEOUT_EN for both
// RTL and bench to include the data-phase timeout case.
// -----------------------------------------------------------------------------
module tb_jtag_ahb_sequencer;

    logic        TCK = 1'b0;
    logic        TRST_N;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [7:0]  cmd_len;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err, rsp_timeout, rsp_last, busy;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HREADY, HRESP;
    logic [2:0]  HSIZE;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    jtag_ahb_sequencer #(
        .LEN_W          (8),
        .ADDR_INC       (4),
        .TIMEOUT_CYCLES (255)
    ) dut (
        .TCK         (TCK),
        .TRST_N      (TRST_N),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_len     (cmd_len),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .rsp_last    (rsp_last),
        .busy        (busy),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HWRITE      (HWRITE),
        .HSIZE       (HSIZE),
        .HWDATA      (HWDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
        .HRDATA      (HRDATA)
    );

    always #5 TCK = ~TCK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one cycle; return 1 time unit after the rising edge.
    task automatic tick();
        @(posedge TCK);
        #1;
    endtask

    // Present a command for one edge; returns in cycle 1 (address phase).
    task automatic start_cmd(input logic wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic [7:0] len);
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = wd;
        cmd_len   = len;
        cmd_valid = 1'b1;
        check_eq("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        TRST_N    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_len   = '0;
        rsp_ready = 1'b1;
        HREADY    = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = '0;
        #1 TRST_N = 1'b0;
        repeat (2) @(posedge TCK);
        #1;
        // ---- reset state ----
        check_eq("rst_htrans", 32'(HTRANS), 32'h0);
        check_eq("rst_haddr", HADDR, 32'h0);
        check_eq("rst_hwdata", HWDATA, 32'h0);
        check_eq("rst_hwrite", 32'(HWRITE), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check_eq("rst_rsp_last", 32'(rsp_last), 32'h0);
        check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
        TRST_N = 1'b1;
        tick();
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'h1);

        // ---- single read, zero wait ----
        HRDATA = 32'hDEADBEEF;
        start_cmd(1'b0, 32'h1000_0000, 32'h0, 8'd0);
        check_eq("rd_c1_htrans", 32'(HTRANS), 32'h2);
        check_eq("rd_c1_haddr", HADDR, 32'h1000_0000);
        check_eq("rd_c1_hwrite", 32'(HWRITE), 32'h0);
        check_eq("rd_c1_hsize", 32'(HSIZE), 32'h2);
        check_eq("rd_c1_busy", 32'(busy), 32'h1);
        check_eq("rd_c1_cmd_ready", 32'(cmd_ready), 32'h0);
        tick();
        check_eq("rd_c2_htrans", 32'(HTRANS), 32'h0);
        check_eq("rd_c2_rsp_valid", 32'(rsp_valid), 32'h0);
        tick();
        check_eq("rd_c3_rsp_valid", 32'(rsp_valid), 32'h1);
        check_eq("rd_c3_rdata", rsp_rdata, 32'hDEADBEEF);
        check_eq("rd_c3_err", 32'(rsp_err), 32'h0);
        check_eq("rd_c3_last", 32'(rsp_last), 32'h1);
        tick();
        check_eq("rd_c4_cmd_ready", 32'(cmd_ready), 32'h1);
        check_eq("rd_c4_busy", 32'(busy), 32'h0);

        // ---- write fill, 4 beats ----
        start_cmd(1'b1, 32'h2000_0000, 32'hA5A5_A5A5, 8'd3);
        for (int b = 0; b < 4; b++) begin
            check_eq($sformatf("wr_b%0d_htrans", b), 32'(HTRANS), 32'h2);
            check_eq($sformatf("wr_b%0d_haddr", b), HADDR, 32'h2000_0000 + 32'(4 * b));
            check_eq($sformatf("wr_b%0d_hwrite", b), 32'(HWRITE), 32'h1);
            tick();
            check_eq($sformatf("wr_b%0d_data_htrans", b), 32'(HTRANS), 32'h0);
            check_eq($sformatf("wr_b%0d_hwdata", b), HWDATA, 32'hA5A5_A5A5);
            tick();
            check_eq($sformatf("wr_b%0d_rsp_valid", b), 32'(rsp_valid), 32'h1);
            check_eq($sformatf("wr_b%0d_rdata", b), rsp_rdata, 32'h0);
            check_eq($sformatf("wr_b%0d_last", b), 32'(rsp_last), (b == 3) ? 32'h1 : 32'h0);
            tick();
        end
        check_eq("wr_end_cmd_ready", 32'(cmd_ready), 32'h1);

        // ---- three wait states in data phase ----
        HRDATA = 32'h1234_5678;
        start_cmd(1'b0, 32'h3000_0010, 32'h0, 8'd0);
        tick();
        HREADY = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            check_eq($sformatf("ws_c%0d_htrans", c), 32'(HTRANS), 32'h0);
            check_eq($sformatf("ws_c%0d_rsp_valid", c), 32'(rsp_valid), 32'h0);
            tick();
        end
        HREADY = 1'b1;
        check_eq("ws_c5_rsp_valid", 32'(rsp_valid), 32'h0);
        tick();
        check_eq("ws_c6_rsp_valid", 32'(rsp_valid), 32'h1);
        check_eq("ws_c6_rdata", rsp_rdata, 32'h1234_5678);
        tick();

        // ---- two-cycle error on beat 2 of 4 ----
        HRDATA = 32'h0BAD_F00D;
        start_cmd(1'b0, 32'h4000_0000, 32'h0, 8'd3);
        check_eq("err_b0_haddr", HADDR, 32'h4000_0000);
        tick();
        tick();
        check_eq("err_b0_err", 32'(rsp_err), 32'h0);
        check_eq("err_b0_last", 32'(rsp_last), 32'h0);
        tick();
        check_eq("err_b1_htrans", 32'(HTRANS), 32'h2);
        check_eq("err_b1_haddr", HADDR, 32'h4000_0004);
        tick();
        HREADY = 1'b0;
        HRESP  = 1'b1;
        check_eq("err_b1_cyc1_htrans", 32'(HTRANS), 32'h0);
        tick();
        HREADY = 1'b1;
        check_eq("err_b1_cyc2_htrans", 32'(HTRANS), 32'h0);
        check_eq("err_b1_cyc2_rsp_valid", 32'(rsp_valid), 32'h0);
        tick();
        HRESP = 1'b0;
        check_eq("err_b1_rsp_valid", 32'(rsp_valid), 32'h1);
        check_eq("err_b1_err", 32'(rsp_err), 32'h1);
        check_eq("err_b1_last", 32'(rsp_last), 32'h1);
        check_eq("err_b1_timeout", 32'(rsp_timeout), 32'h0);
        tick();
        check_eq("err_after_cmd_ready", 32'(cmd_ready), 32'h1);
        check_eq("err_after_htrans", 32'(HTRANS), 32'h0);
        check_eq("err_after_haddr_hold", HADDR, 32'h4000_0004);
        tick();
        check_eq("err_after2_htrans", 32'(HTRANS), 32'h0);
        check_eq("err_after2_rsp_valid", 32'(rsp_valid), 32'h0);

        // ---- backpressure with address wrap ----
        rsp_ready = 1'b0;
        HRDATA    = 32'h1111_1111;
        start_cmd(1'b0, 32'hFFFF_FFFC, 32'h0, 8'd1);
        check_eq("bp_b0_haddr", HADDR, 32'hFFFF_FFFC);
        tick();
        tick();
        HRDATA    = 32'h9999_9999;
        cmd_valid = 1'b1;
        cmd_addr  = 32'h5555_0000;
        for (int s = 0; s < 5; s++) begin
            check_eq($sformatf("bp_s%0d_rsp_valid", s), 32'(rsp_valid), 32'h1);
            check_eq($sformatf("bp_s%0d_htrans", s), 32'(HTRANS), 32'h0);
            check_eq($sformatf("bp_s%0d_rdata", s), rsp_rdata, 32'h1111_1111);
            check_eq($sformatf("bp_s%0d_last", s), 32'(rsp_last), 32'h0);
            check_eq($sformatf("bp_s%0d_cmd_ready", s), 32'(cmd_ready), 32'h0);
            tick();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        check_eq("bp_c8_rsp_valid", 32'(rsp_valid), 32'h1);
        tick();
        HRDATA = 32'h2222_2222;
        check_eq("bp_b1_htrans", 32'(HTRANS), 32'h2);
        check_eq("bp_b1_haddr_wrap", HADDR, 32'h0000_0000);
        tick();
        tick();
        check_eq("bp_b1_rdata", rsp_rdata, 32'h2222_2222);
        check_eq("bp_b1_last", 32'(rsp_last), 32'h1);
        tick();
        check_eq("bp_end_cmd_ready", 32'(cmd_ready), 32'h1);

        // ---- asynchronous reset in the data phase ----
        start_cmd(1'b1, 32'h6000_0000, 32'h0F0F_0F0F, 8'd2);
        tick();
        HREADY = 1'b0;
        check_eq("rstd_hwdata_pre", HWDATA, 32'h0F0F_0F0F);
        #2 TRST_N = 1'b0;
        #1;
        check_eq("rstd_htrans", 32'(HTRANS), 32'h0);
        check_eq("rstd_haddr", HADDR, 32'h0);
        check_eq("rstd_hwdata", HWDATA, 32'h0);
        check_eq("rstd_hwrite", 32'(HWRITE), 32'h0);
        check_eq("rstd_busy", 32'(busy), 32'h0);
        check_eq("rstd_rsp_valid", 32'(rsp_valid), 32'h0);
        tick();
        TRST_N = 1'b1;
        HREADY = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_eq($sformatf("rstd_post%0d_rsp_valid", c), 32'(rsp_valid), 32'h0);
            check_eq($sformatf("rstd_post%0d_cmd_ready", c), 32'(cmd_ready), 32'h1);
        end

`ifdef JTAG_AHB_TIMEOUT_EN
        // ---- data-phase timeout after 255 wait cycles ----
        start_cmd(1'b0, 32'h7000_0000, 32'h0, 8'd2);
        tick();
        HREADY = 1'b0;
        repeat (254) tick();
        check_eq("tmo_c256_rsp_valid", 32'(rsp_valid), 32'h0);
        tick();
        check_eq("tmo_rsp_valid", 32'(rsp_valid), 32'h1);
        check_eq("tmo_err", 32'(rsp_err), 32'h1);
        check_eq("tmo_timeout", 32'(rsp_timeout), 32'h1);
        check_eq("tmo_last", 32'(rsp_last), 32'h1);
        HREADY = 1'b1;
        tick();
        check_eq("tmo_end_cmd_ready", 32'(cmd_ready), 32'h1);
        check_eq("tmo_end_htrans", 32'(HTRANS), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
